// File: rtl/i2s_pkg.sv
// Shared types and constants for the I2S transmit path.
package i2s_pkg;

  typedef enum logic {
    IDLE,
    RUN
  } tx_state_t;

  localparam int unsigned DATA_W_DEF = 16;
  localparam int unsigned DIV_W_DEF  = 8;

  localparam logic WS_LEFT  = 1'b0;
  localparam logic WS_RIGHT = 1'b1;

  // WS leads the data by one bit: it shows the channel of the following bit.
  function automatic logic ws_for_bit(input int unsigned b, input int unsigned dw);
    return ((b >= dw - 1) && (b <= 2 * dw - 2)) ? WS_RIGHT : WS_LEFT;
  endfunction

endpackage

// File: rtl/i2s_sck_gen.sv
// SCK generator: half-period counter against a latched divider, registered sck
// and single-cycle rise/fall strobes marking the cycle in which sck toggles.
module i2s_sck_gen
  import i2s_pkg::*;
#(
  parameter int unsigned DIV_W = DIV_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             start,
  input  logic             load_div,
  input  logic [DIV_W-1:0] div,
  output logic             sck,
  output logic             rise_stb,
  output logic             fall_stb
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_lat_q, div_lat_d;
  logic             sck_q, sck_d;
  logic             tc;

  always_comb begin
    tc        = run && !start && (cnt_q == div_lat_q);
    cnt_d     = cnt_q;
    sck_d     = sck_q;
    div_lat_d = div_lat_q;
    if (start || !run) begin
      cnt_d = '0;
      sck_d = 1'b0;
    end else if (tc) begin
      cnt_d = '0;
      sck_d = ~sck_q;
    end else begin
      cnt_d = cnt_q + DIV_W'(1);
    end
    if (load_div) div_lat_d = div;
    rise_stb = tc && !sck_q;
    fall_stb = tc && sck_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q     <= '0;
      div_lat_q <= '0;
      sck_q     <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      div_lat_q <= div_lat_d;
      sck_q     <= sck_d;
    end
  end

  assign sck = sck_q;

endmodule

// File: rtl/i2s_tx_serializer.sv
// Master-mode I2S transmitter with a one-deep sample buffer.
// I2S_TX_UNDERRUN_REPEAT_EN: an underrun frame repeats the last loaded pair instead of zeros.
module i2s_tx_serializer
  import i2s_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned DIV_W  = DIV_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DIV_W-1:0]  div,
  input  logic              enable,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_left,
  input  logic [DATA_W-1:0] s_right,
  output logic              sck,
  output logic              ws,
  output logic              sd,
  output logic              underrun
);

  localparam int unsigned FW = 2 * DATA_W;
  localparam int unsigned BW = $clog2(FW);
  localparam logic [BW-1:0] B_LAST = BW'(FW - 1);

  tx_state_t        state_q, state_d;
  logic [FW-1:0]    buf_q, buf_d;
  logic             full_q, full_d;
  logic [FW-1:0]    sh_q, sh_d;
  logic [BW-1:0]    b_q, b_d;
  logic             fin_q, fin_d;
  logic             sd_q, sd_d;
  logic             ws_q, ws_d;
  logic             und_q, und_d;
`ifdef I2S_TX_UNDERRUN_REPEAT_EN
  logic [FW-1:0]    last_q, last_d;
`endif

  logic          rise_stb, fall_stb;
  logic          xfer, start, wrap, load;
  logic [FW-1:0] load_word;

  i2s_sck_gen #(.DIV_W(DIV_W)) u_sck_gen (
    .clk      (clk),
    .reset    (reset),
    .run      (state_q == RUN),
    .start    (start),
    .load_div (load),
    .div      (div),
    .sck      (sck),
    .rise_stb (rise_stb),
    .fall_stb (fall_stb)
  );

  always_comb begin
    xfer  = s_valid && !full_q;
    start = (state_q == IDLE) && enable;
    // fin_q is armed at the rising edge of the last bit so the falling edge knows the frame ends.
    wrap  = fall_stb && fin_q;
    load  = start || (wrap && enable);
`ifdef I2S_TX_UNDERRUN_REPEAT_EN
    load_word = full_q ? buf_q : last_q;
    last_d    = last_q;
`else
    load_word = full_q ? buf_q : '0;
`endif
    state_d = state_q;
    buf_d   = buf_q;
    full_d  = full_q;
    sh_d    = sh_q;
    b_d     = b_q;
    fin_d   = fin_q;
    sd_d    = sd_q;
    ws_d    = ws_q;
    und_d   = 1'b0;

    if (rise_stb && (b_q == B_LAST)) fin_d = 1'b1;
    if (fall_stb) fin_d = 1'b0;

    if (state_q == IDLE) begin
      sd_d = 1'b0;
      ws_d = WS_LEFT;
      if (enable) state_d = RUN;
    end else if (wrap && !enable) begin
      state_d = IDLE;
      sd_d    = 1'b0;
      ws_d    = WS_LEFT;
    end else if (fall_stb && !wrap) begin
      b_d  = b_q + BW'(1);
      sd_d = sh_q[FW-1];
      sh_d = {sh_q[FW-2:0], 1'b0};
      ws_d = ws_for_bit(32'(b_q) + 32'd1, DATA_W);
    end

    if (load) begin
      sd_d   = load_word[FW-1];
      sh_d   = {load_word[FW-2:0], 1'b0};
      b_d    = '0;
      fin_d  = 1'b0;
      ws_d   = WS_LEFT;
      und_d  = !full_q;
      full_d = 1'b0;
`ifdef I2S_TX_UNDERRUN_REPEAT_EN
      if (full_q) last_d = buf_q;
`endif
    end

    // A transfer can only land in an empty buffer, so it never collides with the load's read.
    if (xfer) begin
      buf_d  = {s_left, s_right};
      full_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      buf_q   <= '0;
      full_q  <= 1'b0;
      sh_q    <= '0;
      b_q     <= '0;
      fin_q   <= 1'b0;
      sd_q    <= 1'b0;
      ws_q    <= WS_LEFT;
      und_q   <= 1'b0;
`ifdef I2S_TX_UNDERRUN_REPEAT_EN
      last_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      full_q  <= full_d;
      sh_q    <= sh_d;
      b_q     <= b_d;
      fin_q   <= fin_d;
      sd_q    <= sd_d;
      ws_q    <= ws_d;
      und_q   <= und_d;
`ifdef I2S_TX_UNDERRUN_REPEAT_EN
      last_q  <= last_d;
`endif
    end
  end

  assign s_ready  = !full_q;
  assign sd       = sd_q;
  assign ws       = ws_q;
  assign underrun = und_q;

endmodule
